// File: rtl/reaction_auto_player.sv
// Reaction-game auto player: watches the cue LEDs and presses the matching
// KEY after a configurable delay, then re-arms once the LEDs stay dark.
module reaction_auto_player #(
    parameter int unsigned PRESS_CYCLES = 1000,
    parameter int unsigned QUIET_CYCLES = 25_000_000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  led_in,
    input  logic [15:0] delay_cfg,
    output logic [1:0]  KEY,
    output logic        busy,
    output logic [7:0]  press_count,
    output logic        last_target
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_CUE,
        DELAY,
        PRESS
    } state_t;

    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] quiet_q, quiet_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [1:0]       key_q, key_d;
    logic             tgt_q, tgt_d;
    logic [7:0]       pc_q, pc_d;
    logic             last_q, last_d;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            quiet_q <= '0;
            dly_q   <= '0;
            pcnt_q  <= '0;
            key_q   <= 2'b11;
            tgt_q   <= 1'b0;
            pc_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            quiet_q <= quiet_d;
            dly_q   <= dly_d;
            pcnt_q  <= pcnt_d;
            key_q   <= key_d;
            tgt_q   <= tgt_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        quiet_d = quiet_q;
        dly_d   = dly_q;
        pcnt_d  = pcnt_q;
        key_d   = key_q;
        tgt_d   = tgt_q;
        pc_d    = pc_q;
        last_d  = last_q;

        if (!enable) begin
            state_d = IDLE;
            key_d   = 2'b11;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARM;
                    quiet_d = '0;
                    key_d   = 2'b11;
                end
                ARM: begin
                    key_d = 2'b11;
                    // A flashing cue keeps resetting the dark-run count.
                    if (led_in != 2'b00) begin
                        quiet_d = '0;
                    end else if (quiet_q >= QUIET_LAST) begin
                        quiet_d = '0;
                        state_d = WAIT_CUE;
                    end else begin
                        quiet_d = quiet_q + CNT_ONE;
                    end
                end
                WAIT_CUE: begin
                    if (led_in != 2'b00) begin
                        tgt_d   = ~led_in[0];
                        dly_d   = CNT_W'(delay_cfg);
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    if (dly_q == '0) begin
                        state_d = PRESS;
                        pcnt_d  = '0;
                        key_d   = tgt_q ? 2'b01 : 2'b10;
                        last_d  = tgt_q;
                        if (pc_q != 8'hFF) begin
                            pc_d = pc_q + 8'd1;
                        end
                    end else begin
                        dly_d = dly_q - CNT_ONE;
                    end
                end
                PRESS: begin
                    if (pcnt_q >= PRESS_LAST) begin
                        state_d = ARM;
                        quiet_d = '0;
                        key_d   = 2'b11;
                    end else begin
                        pcnt_d = pcnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    key_d   = 2'b11;
                end
            endcase
        end
    end

    assign KEY         = key_q;
    assign busy        = (state_q == ARM) || (state_q == DELAY) ||
                         (state_q == PRESS);
    assign press_count = pc_q;
    assign last_target = last_q;

endmodule

// File: doc/reaction_auto_player.md
REACTION_AUTO_PLAYER -- requirements
Module: reaction_auto_player

Interface
REQ-001 Parameter PRESS_CYCLES, default 1000: number of clocks a KEY bit is held low per press.
REQ-002 Parameter QUIET_CYCLES, default 25_000_000: consecutive all-dark clocks on led_in needed to re-arm; exceeds the LED flash half-period.
REQ-003 Parameter CNT_W, default 32: width of the internal delay, press and quiet counters.
REQ-004 CLOCK_50  input  1  50 MHz clock; the only clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  run control; low forces IDLE.
REQ-007 led_in  input  2  game cue LEDs (LEDR[1:0]), same clock domain, may flash.
REQ-008 delay_cfg  input  16  reaction delay in clocks, sampled at cue detection.
REQ-009 KEY  output  2  emulated push buttons, active-LOW; 1 = released.
REQ-010 busy  output  1  high in every state except IDLE and WAIT_CUE.
REQ-011 press_count  output  8  number of presses issued since reset.
REQ-012 last_target  output  1  index of the KEY bit most recently pressed.

Function
REQ-013 States SHALL be IDLE, ARM, WAIT_CUE, DELAY, PRESS.
REQ-014 IDLE: KEY=2'b11; when enable=1, next state ARM with quiet counter cleared.
REQ-015 ARM: quiet counter increments each clock led_in==2'b00 and clears on any clock led_in!=0; when the count reaches QUIET_CYCLES, next state WAIT_CUE.
REQ-016 WAIT_CUE: on the first clock led_in!=0, latch target (bit 0 has priority if both bits are 1), load the delay counter with delay_cfg, and go to DELAY.
REQ-017 DELAY: delay counter decrements each clock; at 0, go to PRESS; KEY[target] SHALL first read 0 exactly delay_cfg+1 clocks after the detecting edge. delay_cfg=0 gives 1 clock.
REQ-018 PRESS: KEY[target]=0, other bit 1, for exactly PRESS_CYCLES clocks; then ARM with quiet counter cleared and KEY=2'b11.
REQ-019 press_count SHALL increment on entry to PRESS and saturate at 255.
REQ-020 last_target SHALL update on entry to PRESS.
REQ-021 led_in changes during DELAY or PRESS SHALL be ignored. Cue loss does not cancel the press, and a new cue does not retarget it.
REQ-022 enable=0 in any state SHALL force IDLE on the next edge with KEY=2'b11 that cycle. A press in progress is truncated. press_count and last_target are retained.
REQ-023 At most one KEY bit SHALL be low at any time. KEY SHALL be driven from a register, glitch-free.
REQ-024 If enable rises while led_in!=0, no press SHALL occur until QUIET_CYCLES dark clocks are seen in ARM.

Reset
REQ-025 reset=1 SHALL immediately, asynchronously, force state IDLE and KEY=2'b11. It also sets busy=0, press_count=0, last_target=0 and clears all counters.
REQ-026 After reset deasserts, operation SHALL begin at the first rising edge with enable=1.
REQ-027 Reset asserted mid-PRESS SHALL release KEY within the same cycle, without waiting for a clock edge.

Verification (PRESS_CYCLES=4, QUIET_CYCLES=8)
REQ-028 Stimulus: enable=1, led_in=00 for 8 clocks, then led_in=10 with delay_cfg=5. Response: KEY=01 from clock 6 after detection for 4 clocks, then 11; press_count=1; last_target=1.
REQ-029 Stimulus: cue led_in=11 with delay_cfg=0. Response: KEY=10 one clock after detection; last_target=0.
REQ-030 Stimulus: led_in flashing 10/00 with 3-clock half-period, after one press. Response: no second press; stays ARM while flashing, reaches WAIT_CUE after 8 dark clocks.
REQ-031 Stimulus: enable dropped on the 2nd PRESS clock. Response: KEY=11 next clock, state IDLE, press_count unchanged.
REQ-032 Stimulus: reset pulsed mid-DELAY and mid-PRESS. Response: KEY=11 asynchronously; press_count=0; busy=0.
REQ-033 Stimulus: 260 cue/quiet cycles. Response: press_count saturates at 255.
